// File: rtl/d_cache_2way.sv
// d_cache_2way: two-way set-associative write-back/write-allocate data cache, per-set LRU, one word per bus beat.
// Define DCACHE_UNCACHED_EN to enable the single-access uncached bypass path.
module d_cache_2way #(
    parameter int A_WIDTH  = 32,
    parameter int C_INDEX  = 6,
    parameter int LINE_OFF = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memenM,
    input  logic        memwriteM,
    input  logic [3:0]  sel,
    input  logic [1:0]  data_sram_size,
    input  logic [31:0] data_paddr,
    input  logic [31:0] writedata2M,
    input  logic        uncached,
    output logic [31:0] readdataM,
    output logic        cache_ready,
    output logic        data_req,
    output logic        data_wr,
    output logic [3:0]  data_wen,
    output logic [1:0]  data_size,
    output logic [31:0] data_addr,
    output logic [31:0] data_wdata,
    input  logic [31:0] data_rdata,
    input  logic        data_addr_ok,
    input  logic        data_data_ok
);
    localparam int TAG_W = A_WIDTH - C_INDEX - LINE_OFF - 2;
    localparam int SETS  = 1 << C_INDEX;
    localparam int WORDS = SETS << LINE_OFF;

    typedef enum logic [1:0] {IDLE, WB, RF, UC} state_t;
    state_t state, state_n;

    logic [TAG_W-1:0]    tag_q [2][SETS];
    logic [31:0]         data_q [2][WORDS];
    logic [SETS-1:0]     valid_q [2];
    logic [SETS-1:0]     dirty_q [2];
    logic [SETS-1:0]     lru_q;
    logic [LINE_OFF-1:0] cnt;
    logic                vic, req;

    logic [TAG_W-1:0]    tag;
    logic [C_INDEX-1:0]  idx;
    logic [LINE_OFF-1:0] off;
    logic hit0, hit1, hit, hw, vic_n, last, start, uc_sel;

    assign tag   = data_paddr[A_WIDTH-1 -: TAG_W];
    assign idx   = data_paddr[LINE_OFF+2 +: C_INDEX];
    assign off   = data_paddr[2 +: LINE_OFF];
    assign hit0  = valid_q[0][idx] && tag_q[0][idx] == tag;
    assign hit1  = valid_q[1][idx] && tag_q[1][idx] == tag;
    assign hw    = hit1;
    assign hit   = memenM && state == IDLE && !uc_sel && (hit0 || hit1);
    // Empty ways are filled first (way0 preferred), otherwise the LRU bit names the victim
    assign vic_n = !valid_q[0][idx] ? 1'b0 : !valid_q[1][idx] ? 1'b1 : lru_q[idx];
    assign last  = data_data_ok && cnt == '1;

`ifdef DCACHE_UNCACHED_EN
    assign uc_sel = uncached;
`else
    logic unused_ok;
    assign uc_sel    = 1'b0;
    assign unused_ok = uncached;
`endif

    always_comb begin
        state_n = state;
        state_n = state == IDLE ? (!memenM ? IDLE : uc_sel ? UC : (hit0 || hit1) ? IDLE :
                                   dirty_q[vic_n][idx] ? WB : RF) :
                  state == WB   ? (last ? RF : WB) :
                  state == RF   ? (last ? IDLE : RF) :
                                  (data_data_ok ? IDLE : UC);
    end

    // A new beat is requested on phase entry and after every data_ok that leaves work to do
    assign start = (state == IDLE && state_n != IDLE) || (state == WB && data_data_ok) ||
                   (state == RF && data_data_ok && !last);

    assign cache_ready = hit || (state == UC && data_data_ok);
    assign readdataM   = state == UC ? data_rdata : data_q[hw][{idx, off}];
    assign data_req    = req;
    assign data_wr     = state == WB || (state == UC && memwriteM);
    assign data_wen    = state == WB ? 4'b1111 : state == UC ? sel : 4'b0000;
    assign data_size   = state == UC ? data_sram_size : 2'b10;
    assign data_addr   = state == WB ? 32'({tag_q[vic][idx], idx, cnt, 2'b00}) :
                         state == RF ? 32'({tag, idx, cnt, 2'b00}) :
                         state == UC ? data_paddr : 32'h0;
    assign data_wdata  = state == WB ? data_q[vic][{idx, cnt}] : state == UC ? writedata2M : 32'h0;

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            dirty_q[0] <= '0;
            dirty_q[1] <= '0;
            lru_q      <= '0;
            cnt        <= '0;
            req        <= 1'b0;
            vic        <= 1'b0;
        end else begin
            req <= start || (req && !data_addr_ok);
            if (state == IDLE) vic <= vic_n;
            if ((state == WB || state == RF) && data_data_ok) cnt <= cnt + 1'b1;
            if (hit) begin
                lru_q[idx] <= !hw;
                if (memwriteM) dirty_q[hw][idx] <= 1'b1;
            end
            if (state == RF && last) begin
                valid_q[vic][idx] <= 1'b1;
                dirty_q[vic][idx] <= 1'b0;
                lru_q[idx]        <= !vic;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst && hit && memwriteM)
            for (int b = 0; b < 4; b++)
                if (sel[b]) data_q[hw][{idx, off}][8*b +: 8] <= writedata2M[8*b +: 8];
        if (rst && state == RF && data_data_ok) data_q[vic][{idx, cnt}] <= data_rdata;
        if (rst && state == RF && last) tag_q[vic][idx] <= tag;
    end
endmodule

// File: tb/tb_d_cache_2way.sv
// tb_d_cache_2way: directed and random accesses checked against a flat memory plus per-set recency model.
// Address split for the default parameters: tag [31:10], index [9:4], word offset [3:2].
module tb_d_cache_2way;
    logic        clk = 1'b0, rst = 1'b0;
    logic        memenM, memwriteM, uncached;
    logic [3:0]  sel;
    logic [1:0]  data_sram_size;
    logic [31:0] data_paddr, writedata2M, readdataM;
    logic        cache_ready, data_req, data_wr;
    logic [3:0]  data_wen;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        data_addr_ok, data_data_ok;

    d_cache_2way dut (
        .clk(clk), .rst(rst), .memenM(memenM), .memwriteM(memwriteM), .sel(sel),
        .data_sram_size(data_sram_size), .data_paddr(data_paddr), .writedata2M(writedata2M),
        .uncached(uncached), .readdataM(readdataM), .cache_ready(cache_ready),
        .data_req(data_req), .data_wr(data_wr), .data_wen(data_wen), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_rdata(data_rdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic        w;
        logic [31:0] d;
        logic [3:0]  e;
        logic [1:0]  z;
    } txn_t;

    txn_t        log_q[$];
    txn_t        exp_q[$];
    logic [31:0] bmem [logic [31:0]];
    logic [31:0] ovl [logic [31:0]];
    bit          dirty [logic [31:0]];
    logic [21:0] rec [64][$];
    bit          hit_e;
    int          n_pass = 0, n_fail = 0, n_chk = 0, force_ad = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic [31:0] a, input logic w, input logic [31:0] d,
                                input logic [3:0] e, input logic [1:0] z);
        txn_t x;
        x.a = a; x.w = w; x.d = d; x.e = e; x.z = z;
        return x;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] en);
        for (int b = 0; b < 4; b++) if (en[b]) old[8*b +: 8] = nw[8*b +: 8];
        return old;
    endfunction

    function automatic logic [31:0] bus_view(input logic [31:0] a);
        return bmem.exists(a) ? bmem[a] : {~a[15:0], a[15:0]};
    endfunction

    function automatic logic [31:0] cpu_view(input logic [31:0] a);
        return ovl.exists(a) ? ovl[a] : bus_view(a);
    endfunction

    // Recency list per set: front is least recently used; a third line evicts the front
    task automatic predict(input logic [31:0] a);
        logic [5:0]  s = a[9:4];
        logic [21:0] t = a[31:10];
        logic [31:0] vb;
        int hi = -1;
        exp_q = {};
        for (int i = 0; i < rec[s].size(); i++) if (rec[s][i] == t) hi = i;
        hit_e = hi >= 0;
        if (hit_e) rec[s].delete(hi);
        else begin
            if (rec[s].size() == 2) begin
                vb = {rec[s].pop_front(), s, 4'b0};
                if (dirty.exists(vb)) begin
                    for (int w = 0; w < 4; w++) exp_q.push_back(mk(vb + 32'(4*w), 1'b1, cpu_view(vb + 32'(4*w)), 4'hf, 2'b10));
                    dirty.delete(vb);
                end
            end
            for (int w = 0; w < 4; w++) exp_q.push_back(mk({a[31:4], 4'b0} + 32'(4*w), 1'b0, 32'h0, 4'h0, 2'b10));
        end
        rec[s].push_back(t);
    endtask

    task automatic model_reset();
        for (int s = 0; s < 64; s++) rec[s] = {};
        dirty.delete();
        ovl.delete();
    endtask

    task automatic cmp_log(input string tag);
        chk({tag, " txn count"}, 32'(log_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < log_q.size() && i < exp_q.size(); i++) begin
            chk({tag, " bus addr"}, log_q[i].a, exp_q[i].a);
            chk({tag, " bus wr"}, 32'(log_q[i].w), 32'(exp_q[i].w));
            chk({tag, " bus size"}, 32'(log_q[i].z), 32'(exp_q[i].z));
            if (exp_q[i].w) begin
                chk({tag, " bus wdata"}, log_q[i].d, exp_q[i].d);
                chk({tag, " bus wen"}, 32'(log_q[i].e), 32'(exp_q[i].e));
            end
        end
        log_q = {};
    endtask

    task automatic access(input string tag, input logic wr, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] wd, input logic unc);
        logic [31:0] expd;
        int n;
        bit uc;
`ifdef DCACHE_UNCACHED_EN
        uc = unc;
`else
        uc = 1'b0;
`endif
        log_q = {};
        if (uc) begin
            exp_q = {};
            exp_q.push_back(mk(a, wr, wd, s, 2'b10));
            expd = bus_view(a);
        end else begin
            predict(a);
            expd = cpu_view(a);
        end
        memenM = 1'b1; memwriteM = wr; sel = s; data_paddr = a; writedata2M = wd; uncached = unc;
        n = 0;
        forever begin
            @(negedge clk); #1;
            if (cache_ready || n > 500) break;
            n++;
        end
        chk({tag, " ready"}, 32'(cache_ready), 32'h1);
        if (uc) chk({tag, " ready with data_ok"}, 32'(data_data_ok), 32'h1);
        else    chk({tag, " hit same cycle"}, 32'(n == 0), 32'(hit_e));
        if (!wr) chk({tag, " rdata"}, readdataM, expd);
        @(posedge clk); #1;
        memenM = 1'b0; memwriteM = 1'b0; uncached = 1'b0;
        cmp_log(tag);
        if (wr && !uc) begin
            ovl[a] = merge(cpu_view(a), wd, s);
            dirty[{a[31:4], 4'b0}] = 1'b1;
        end
    endtask

    // Bus slave: random addr_ok/data_ok delays, one beat at a time, logs every accepted beat
    initial begin
        bit pa = 1'b0, pd = 1'b0;
        int ad = 0, dd = 0;
        txn_t cap;
        logic [31:0] rd = 32'h0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;
        forever begin
            @(negedge clk);
            data_addr_ok = 1'b0; data_data_ok = 1'b0;
            if (!rst) begin
                pa = 1'b0; pd = 1'b0;
            end else if (pd) begin
                chk("one outstanding", 32'(data_req), 32'h0);
                dd--;
                if (dd == 0) begin data_data_ok = 1'b1; data_rdata = rd; pd = 1'b0; end
            end else if (data_req) begin
                if (!pa) begin
                    cap = mk(data_addr, data_wr, data_wdata, data_wen, data_size);
                    ad = force_ad >= 0 ? force_ad : int'($urandom_range(0, 3));
                    pa = 1'b1;
                end else begin
                    chk("hold addr", data_addr, cap.a);
                    chk("hold wr", 32'(data_wr), 32'(cap.w));
                    chk("hold wdata", data_wdata, cap.d);
                end
                if (ad == 0) begin
                    pa = 1'b0;
                    log_q.push_back(cap);
                    if (cap.w) bmem[cap.a] = merge(bus_view(cap.a), cap.d, cap.e);
                    else rd = bus_view(cap.a);
                    data_addr_ok = 1'b1;
                    dd = int'($urandom_range(0, 2));
                    if (dd == 0) begin data_data_ok = 1'b1; data_rdata = rd; end
                    else pd = 1'b1;
                end else ad--;
            end
        end
    end

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic [31:0] a;
        memenM = 1'b0; memwriteM = 1'b0; uncached = 1'b0; sel = 4'h0;
        data_sram_size = 2'b10; data_paddr = 32'h0; writedata2M = 32'h0;
        bmem[32'h1000] = 32'hA0A0_0000;
        bmem[32'h1004] = 32'hA1A1_1111;
        bmem[32'h1008] = 32'hA2A2_2222;
        bmem[32'h100C] = 32'hA3A3_3333;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset data_req", 32'(data_req), 32'h0);
        chk("reset data_wr", 32'(data_wr), 32'h0);
        chk("reset data_addr", data_addr, 32'h0);
        chk("reset cache_ready", 32'(cache_ready), 32'h0);
        @(posedge clk); #1; rst = 1'b1;

        access("s1 miss", 1'b0, 32'h0000_1004, 4'hf, 32'h0, 1'b0);
        access("s1 hit", 1'b0, 32'h0000_1008, 4'hf, 32'h0, 1'b0);
        access("s2 full store", 1'b1, 32'h0000_1004, 4'b1111, 32'h1122_3344, 1'b0);
        access("s2 byte store", 1'b1, 32'h0000_1004, 4'b0011, 32'h0000_BEEF, 1'b0);
        access("s2 load", 1'b0, 32'h0000_1004, 4'hf, 32'h0, 1'b0);
        chk("s2 merged word", readdataM, 32'h1122_BEEF);
        access("s3 fill way1", 1'b0, 32'h0000_2004, 4'hf, 32'h0, 1'b0);
        access("s3 touch", 1'b0, 32'h0000_1004, 4'hf, 32'h0, 1'b0);
        access("s3 evict", 1'b0, 32'h0000_3004, 4'hf, 32'h0, 1'b0);
        access("s3 keep", 1'b0, 32'h0000_1004, 4'hf, 32'h0, 1'b0);
        access("s4 store", 1'b1, 32'h0000_2008, 4'b0101, 32'hCAFE_F00D, 1'b0);
        access("s4 touch", 1'b0, 32'h0000_1004, 4'hf, 32'h0, 1'b0);
        access("s4 dirty evict", 1'b0, 32'h0000_4000, 4'hf, 32'h0, 1'b0);
        access("s4 reload", 1'b0, 32'h0000_2008, 4'hf, 32'h0, 1'b0);
        force_ad = 3;
        access("s5 slow addr_ok", 1'b0, 32'h0000_5040, 4'hf, 32'h0, 1'b0);
        force_ad = -1;

        // memenM dropped after the miss is taken: refill still completes silently
        predict(32'h0000_8034);
        log_q = {};
        memenM = 1'b1; data_paddr = 32'h0000_8034;
        @(posedge clk); #1; memenM = 1'b0;
        n = 0;
        while (log_q.size() < 4 && n < 300) begin
            @(negedge clk); #1;
            chk("drop no ready", 32'(cache_ready), 32'h0);
            n++;
        end
        repeat (6) @(posedge clk);
        #1;
        cmp_log("drop");
        access("drop then hit", 1'b0, 32'h0000_8034, 4'hf, 32'h0, 1'b0);

        // reset while a refill is in flight
        log_q = {};
        memenM = 1'b1; data_paddr = 32'h0000_7020;
        n = 0;
        while (log_q.size() < 2 && n < 300) begin @(negedge clk); #1; n++; end
        chk("mid rf reached", 32'(log_q.size() >= 2), 32'h1);
        @(posedge clk); #1; rst = 1'b0; memenM = 1'b0;
        @(posedge clk); #1; rst = 1'b1;
        model_reset();
        chk("mid reset data_req", 32'(data_req), 32'h0);
        chk("mid reset data_addr", data_addr, 32'h0);
        access("after reset miss", 1'b0, 32'h0000_7020, 4'hf, 32'h0, 1'b0);
        access("after reset old line", 1'b0, 32'h0000_1004, 4'hf, 32'h0, 1'b0);

`ifdef DCACHE_UNCACHED_EN
        access("s6 uc load", 1'b0, 32'h1FC0_0000, 4'b1111, 32'h0, 1'b1);
        access("s6 cached load", 1'b0, 32'h1FC0_0000, 4'hf, 32'h0, 1'b0);
        access("s6 uc store", 1'b1, 32'h1FC0_0140, 4'b0101, 32'h1234_5678, 1'b1);
        access("s6 uc reload", 1'b0, 32'h1FC0_0140, 4'b1111, 32'h0, 1'b1);
`else
        access("uncached ignored", 1'b0, 32'h1FC0_0000, 4'b1111, 32'h0, 1'b1);
        access("uncached ignored hit", 1'b0, 32'h1FC0_0004, 4'b1111, 32'h0, 1'b1);
`endif

        for (int i = 0; i < 150; i++) begin
            a = {22'($urandom_range(1, 3)), 6'($urandom_range(8, 10)), 2'($urandom_range(0, 3)), 2'b00};
            access("rand", 1'($urandom_range(0, 1)), a, 4'($urandom_range(0, 15)), $urandom, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
